// File: rtl/paddle_line_scheduler.sv
// Paddle position integrator and per-scanline strobe scheduler for the AY-3-8500 paddle pins.
// Define PADDLE_ABS_EN to add absolute position inputs (abs_sel, abs1, abs2).
module paddle_line_scheduler #(
    parameter int POS_W      = 9,
    parameter int POS_INIT   = 128,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 255,
    parameter int SPEED_SLOW = 5,
    parameter int SPEED_FAST = 8
) (
    input  logic             clk_16M,
    input  logic             reset,
    input  logic             hs,
    input  logic             vs,
    input  logic             up1,
    input  logic             down1,
    input  logic             up2,
    input  logic             down2,
    input  logic             fast,
    input  logic             freeze,
`ifdef PADDLE_ABS_EN
    input  logic             abs_sel,
    input  logic [7:0]       abs1,
    input  logic [7:0]       abs2,
`endif
    output logic             lp_in,
    output logic             rp_in,
    output logic [POS_W-1:0] p1_pos,
    output logic [POS_W-1:0] p2_pos,
    output logic             frame_tick,
    output logic             dbg_state
);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    localparam logic [POS_W:0]   MIN_W  = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]   MAX_W  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   SLOW_W = (POS_W+1)'(SPEED_SLOW);
    localparam logic [POS_W:0]   FAST_W = (POS_W+1)'(SPEED_FAST);
    localparam logic [POS_W-1:0] INIT_V = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] ONE_V  = POS_W'(1);

    // Saturating integration, one bit wider so the bounds tests cannot wrap.
    function automatic logic [POS_W-1:0] integrate(
        input logic [POS_W-1:0] pos,
        input logic             up,
        input logic             dn,
        input logic [POS_W:0]   step
    );
        logic [POS_W:0] pos_w;
        logic [POS_W:0] res;
        pos_w = {1'b0, pos};
        res   = pos_w;
        if (up) begin
            res = (pos_w < MIN_W + step) ? MIN_W : pos_w - step;
        end else if (dn) begin
            res = (pos_w > MAX_W - step) ? MAX_W : pos_w + step;
        end
        return POS_W'(res);
    endfunction

`ifdef PADDLE_ABS_EN
    function automatic logic [POS_W-1:0] abs_clamp(input logic [7:0] a);
        logic [POS_W:0] a_w;
        logic [POS_W:0] res;
        a_w = (POS_W+1)'(a);
        res = a_w;
        if (a_w < MIN_W) begin
            res = MIN_W;
        end else if (a_w > MAX_W) begin
            res = MAX_W;
        end
        return POS_W'(res);
    endfunction
`endif

    logic           hs_sync_q, hs_hist_q;
    logic           vs_sync_q, vs_hist_q;
    logic           hs_rise, vs_rise;
    state_t         state_q, state_d;
    logic [POS_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [POS_W-1:0] cap1_q, cap1_d, cap2_q, cap2_d;
    logic [POS_W:0]   step_w;
    logic           lp_q, lp_d, rp_q, rp_d, tick_q, tick_d;

    always_ff @(posedge clk_16M) begin
        if (reset) begin
            hs_sync_q <= 1'b0;
            hs_hist_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_hist_q <= 1'b0;
        end else begin
            hs_sync_q <= hs;
            hs_hist_q <= hs_sync_q;
            vs_sync_q <= vs;
            vs_hist_q <= vs_sync_q;
        end
    end

    assign hs_rise = hs_sync_q & ~hs_hist_q;
    assign vs_rise = vs_sync_q & ~vs_hist_q;

    always_ff @(posedge clk_16M) begin
        if (reset) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (vs_rise) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    // Strobes are gated by RUN so the zeroed reset caps do not fire before the first frame.
    always_comb begin
        lp_d   = (state_q == RUN) && (cap1_q == '0);
        rp_d   = (state_q == RUN) && (cap2_q == '0);
        tick_d = vs_rise;
    end

    always_comb begin
        step_w = fast ? FAST_W : SLOW_W;
        p1_d   = p1_q;
        p2_d   = p2_q;
        cap1_d = cap1_q;
        cap2_d = cap2_q;
        if (vs_rise) begin
            cap1_d = p1_q;
            cap2_d = p2_q;
            if (!freeze) begin
`ifdef PADDLE_ABS_EN
                if (abs_sel) begin
                    p1_d = abs_clamp(abs1);
                    p2_d = abs_clamp(abs2);
                end else begin
                    p1_d = integrate(p1_q, up1, down1, step_w);
                    p2_d = integrate(p2_q, up2, down2, step_w);
                end
`else
                p1_d = integrate(p1_q, up1, down1, step_w);
                p2_d = integrate(p2_q, up2, down2, step_w);
`endif
            end
        end else if (hs_rise && (state_q == RUN)) begin
            if (cap1_q != '0) cap1_d = cap1_q - ONE_V;
            if (cap2_q != '0) cap2_d = cap2_q - ONE_V;
        end
    end

    always_ff @(posedge clk_16M) begin
        if (reset) begin
            p1_q   <= INIT_V;
            p2_q   <= INIT_V;
            cap1_q <= '0;
            cap2_q <= '0;
            lp_q   <= 1'b0;
            rp_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            cap1_q <= cap1_d;
            cap2_q <= cap2_d;
            lp_q   <= lp_d;
            rp_q   <= rp_d;
            tick_q <= tick_d;
        end
    end

    assign lp_in      = lp_q;
    assign rp_in      = rp_q;
    assign p1_pos     = p1_q;
    assign p2_pos     = p2_q;
    assign frame_tick = tick_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_paddle_line_scheduler.sv
// Scoreboard bench for paddle_line_scheduler: frame positions, line strobes, sync edge cases.
`timescale 1ns/1ps
module tb_paddle_line_scheduler;

    localparam int POS_W = 9;

    logic clk_16M = 1'b0;
    logic reset, hs, vs, up1, down1, up2, down2, fast, freeze;
`ifdef PADDLE_ABS_EN
    logic abs_sel;
    logic [7:0] abs1, abs2;
`endif
    logic lp_in, rp_in, frame_tick, dbg_state;
    logic [POS_W-1:0] p1_pos, p2_pos;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*POS_W-1:0] exp_q[$];
    int m_p1, m_p2, m_cap1, m_cap2;

    paddle_line_scheduler dut (
        .clk_16M    (clk_16M),
        .reset      (reset),
        .hs         (hs),
        .vs         (vs),
        .up1        (up1),
        .down1      (down1),
        .up2        (up2),
        .down2      (down2),
        .fast       (fast),
        .freeze     (freeze),
`ifdef PADDLE_ABS_EN
        .abs_sel    (abs_sel),
        .abs1       (abs1),
        .abs2       (abs2),
`endif
        .lp_in      (lp_in),
        .rp_in      (rp_in),
        .p1_pos     (p1_pos),
        .p2_pos     (p2_pos),
        .frame_tick (frame_tick),
        .dbg_state  (dbg_state)
    );

    always #31 clk_16M = ~clk_16M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_step(input int pos, input logic up, input logic dn, input logic f);
        int step;
        step = f ? 8 : 5;
        if (up) return (pos - step < 0) ? 0 : pos - step;
        if (dn) return (pos + step > 255) ? 255 : pos + step;
        return pos;
    endfunction

`ifdef PADDLE_ABS_EN
    function automatic int model_abs(input logic [7:0] a);
        int v;
        v = a;
        return (v > 255) ? 255 : v;
    endfunction
`endif

    task automatic do_reset();
        @(negedge clk_16M);
        reset = 1'b1;
        @(negedge clk_16M);
        @(negedge clk_16M);
        reset = 1'b0;
        m_p1 = 128;
        m_p2 = 128;
        m_cap1 = 0;
        m_cap2 = 0;
        exp_q.delete();
        @(negedge clk_16M);
    endtask

    task automatic vs_frame(input bit with_hs);
        logic [2*POS_W-1:0] e;
        int cyc;
        m_cap1 = m_p1;
        m_cap2 = m_p2;
        if (!freeze) begin
`ifdef PADDLE_ABS_EN
            if (abs_sel) begin
                m_p1 = model_abs(abs1);
                m_p2 = model_abs(abs2);
            end else begin
                m_p1 = model_step(m_p1, up1, down1, fast);
                m_p2 = model_step(m_p2, up2, down2, fast);
            end
`else
            m_p1 = model_step(m_p1, up1, down1, fast);
            m_p2 = model_step(m_p2, up2, down2, fast);
`endif
        end
        exp_q.push_back({POS_W'(m_p1), POS_W'(m_p2)});
        vs = 1'b1;
        if (with_hs) hs = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_16M);
            cyc++;
        end while (!frame_tick && cyc < 8);
        check("tick_seen", frame_tick, 1);
        e = exp_q.pop_front();
        check("p1_pos", p1_pos, e[2*POS_W-1:POS_W]);
        check("p2_pos", p2_pos, e[POS_W-1:0]);
        check("state_run", dbg_state, 1);
        @(negedge clk_16M);
        check("tick_width", frame_tick, 0);
        check("lp_frame_start", lp_in, m_cap1 == 0);
        check("rp_frame_start", rp_in, m_cap2 == 0);
        vs = 1'b0;
        hs = 1'b0;
        @(negedge clk_16M);
        @(negedge clk_16M);
    endtask

    task automatic hs_pulse(output logic lp_a, output logic rp_a, output logic lp_b, output logic rp_b);
        hs = 1'b1;
        @(negedge clk_16M);
        @(negedge clk_16M);
        lp_a = lp_in;
        rp_a = rp_in;
        hs = 1'b0;
        @(negedge clk_16M);
        lp_b = lp_in;
        rp_b = rp_in;
        @(negedge clk_16M);
    endtask

    task automatic run_lines(input int n);
        logic la, ra, lb, rb;
        for (int k = 1; k <= n; k++) begin
            hs_pulse(la, ra, lb, rb);
            check("lp_line", lb, k >= m_cap1);
            check("rp_line", rb, k >= m_cap2);
            if (k == m_cap1) check("lp_not_early", la, 0);
            if (k == m_cap2) check("rp_not_early", ra, 0);
        end
    endtask

    initial begin
        logic la, ra, lb, rb;
        reset = 1'b1; hs = 1'b0; vs = 1'b0;
        up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
        fast = 1'b0; freeze = 1'b0;
`ifdef PADDLE_ABS_EN
        abs_sel = 1'b0; abs1 = 8'd0; abs2 = 8'd0;
`endif
        repeat (3) @(negedge clk_16M);
        reset = 1'b0;
        m_p1 = 128; m_p2 = 128; m_cap1 = 0; m_cap2 = 0;
        @(negedge clk_16M);
        check("rst_p1", p1_pos, 128);
        check("rst_p2", p2_pos, 128);
        check("rst_lp", lp_in, 0);
        check("rst_rp", rp_in, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_state", dbg_state, 0);

        // hs without any vs: still waiting for the first frame
        for (int i = 0; i < 5; i++) begin
            hs_pulse(la, ra, lb, rb);
            check("wait_lp", lb, 0);
            check("wait_rp", rb, 0);
        end
        check("wait_state", dbg_state, 0);
        check("wait_p1", p1_pos, 128);

        // first frame: slow down step, strobe at line 128
        down1 = 1'b1;
        vs_frame(0);
        down1 = 1'b0;
        run_lines(130);

        // fast up from 128 down to the floor and beyond
        do_reset();
        up1 = 1'b1; fast = 1'b1;
        repeat (20) begin
            vs_frame(0);
            run_lines(12);
        end
        up1 = 1'b0;

        // player 2 to 250 then saturate at 255
        fast = 1'b0; down2 = 1'b1;
        repeat (2) begin vs_frame(0); run_lines(3); end
        fast = 1'b1;
        repeat (16) begin vs_frame(0); run_lines(3); end
        check("p2_sat", p2_pos, 255);
        down2 = 1'b0;

        // player 2 to 100, then both controls: up wins
        do_reset();
        up2 = 1'b1; fast = 1'b1;
        vs_frame(0);
        fast = 1'b0;
        repeat (4) vs_frame(0);
        down2 = 1'b1;
        vs_frame(0);
        check("p2_up_wins", p2_pos, 95);
        up2 = 1'b0; down2 = 1'b0;

        // vs and hs rise together: hs must be discarded
        vs_frame(1);
        run_lines(100);

        // freeze holds positions, line timing repeats
        freeze = 1'b1; down1 = 1'b1;
        repeat (3) begin
            vs_frame(0);
            run_lines(130);
        end
        freeze = 1'b0; down1 = 1'b0;

`ifdef PADDLE_ABS_EN
        abs_sel = 1'b1; abs1 = 8'd200; abs2 = 8'd17;
        vs_frame(0);
        check("abs_p1", p1_pos, 200);
        abs_sel = 1'b0;
        run_lines(4);
`endif

        // reset from RUN
        @(negedge clk_16M);
        reset = 1'b1;
        @(negedge clk_16M);
        check("rerst_state", dbg_state, 0);
        check("rerst_lp", lp_in, 0);
        check("rerst_rp", rp_in, 0);
        check("rerst_p1", p1_pos, 128);
        check("rerst_tick", frame_tick, 0);
        reset = 1'b0;
        @(negedge clk_16M);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
